// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between an initiator and mem_responder
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word memory responder with fixed response latency
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int         IW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;

    logic            r_write;
    logic [IW-1:0]   r_idx;
    logic            r_misalign;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_commit;
    logic            w_cur_write;
    logic            w_cur_misalign;
    logic [IW-1:0]   w_cur_idx;
    logic [31:0]     w_cur_wdata;

    // With LATENCY=1 the request enters RESP on its accepting edge, so the
    // live bus fields are used instead of the (not yet latched) copies.
    assign w_cur_write    = (r_state == IDLE) ? bus.req_write                : r_write;
    assign w_cur_idx      = (r_state == IDLE) ? bus.req_addr[IW+1:2]         : r_idx;
    assign w_cur_misalign = (r_state == IDLE) ? (bus.req_addr[1:0] != 2'b00) : r_misalign;
    assign w_cur_wdata    = (r_state == IDLE) ? bus.req_wdata                : r_wdata;

    assign w_commit = w_enter_resp && w_cur_write && !w_cur_misalign;

    // Counter holds the remaining WAIT cycles; the exit on zero places
    // resp_valid exactly LATENCY edges after acceptance.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_next     = IDLE;
                    w_cnt_next = 4'd0;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_misalign <= 1'b0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_idx      <= bus.req_addr[IW+1:2];
                r_misalign <= (bus.req_addr[1:0] != 2'b00);
                r_wdata    <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_err   <= w_cur_misalign;
                r_rdata <= (w_cur_write || w_cur_misalign) ? 32'd0 : r_mem[w_cur_idx];
            end
        end
    end

    // Storage is deliberately outside reset; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (reset && w_commit) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed table-driven bench for mem_responder
module tb_mem_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_responder_if bus4();
    mem_responder_if bus1();

    mem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int cyc;
        check({tag, "_req_ready"}, 32'(bus4.req_ready), 32'd1);
        bus4.req_valid = 1'b1;
        bus4.req_write = wr;
        bus4.req_addr  = addr;
        bus4.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        cyc = 0;
        while (!bus4.resp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd4);
        check({tag, "_rdata"}, bus4.resp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(bus4.resp_err), 32'(exp_err));
        bus4.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.resp_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(bus4.busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h2222_2222, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h2222_2222, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_1FFC, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};

        reset = 1'b0;
        bus4.req_valid = 1'b0; bus4.req_write = 1'b0; bus4.req_addr = 32'd0;
        bus4.req_wdata = 32'd0; bus4.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'd0;
        bus1.req_wdata = 32'd0; bus1.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(bus4.resp_valid), 32'd0);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_rdata", bus4.resp_rdata, 32'd0);
        check("rst_err", 32'(bus4.resp_err), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus4.req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            transact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                     vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Backpressure: response must hold while resp_ready is low.
        bus4.req_valid = 1'b1;
        bus4.req_write = 1'b0;
        bus4.req_addr  = 32'h0000_0010;
        @(posedge clk);
        #1;
        bus4.req_addr  = 32'h0000_0020;
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid_rise", 32'(bus4.resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(bus4.resp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", i), bus4.resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("bp%0d_req_ready", i), 32'(bus4.req_ready), 32'd0);
            check($sformatf("bp%0d_busy", i), 32'(bus4.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        bus4.req_valid  = 1'b0;
        bus4.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.resp_ready = 1'b0;
        check("bp_release_ready", 32'(bus4.req_ready), 32'd1);
        check("bp_release_valid", 32'(bus4.resp_valid), 32'd0);

        // Reset two cycles after accepting a store aborts it.
        bus4.req_valid = 1'b1;
        bus4.req_write = 1'b1;
        bus4.req_addr  = 32'h0000_0020;
        bus4.req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_busy", 32'(bus4.busy), 32'd0);
        check("rstmid_valid", 32'(bus4.resp_valid), 32'd0);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (bus4.resp_valid) seen++;
            end
            check("rstmid_no_resp", 32'(seen), 32'd0);
        end
        transact(1'b0, 32'h0000_0020, 32'd0, 32'h2222_2222, 1'b0, "rstmid_load");

        // LATENCY=1 instance: req_valid and resp_ready held high.
        bus1.req_valid  = 1'b1;
        bus1.req_write  = 1'b1;
        bus1.req_addr   = 32'h0000_0004;
        bus1.req_wdata  = 32'h0000_0077;
        bus1.resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("l1_c%0d_ready", i), 32'(bus1.req_ready), 32'((i % 2) == 0));
            check($sformatf("l1_c%0d_valid", i), 32'(bus1.resp_valid), 32'((i % 2) == 1));
            @(posedge clk);
            #1;
        end
        bus1.req_write = 1'b0;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        check("l1_load_valid", 32'(bus1.resp_valid), 32'd1);
        check("l1_load_rdata", bus1.resp_rdata, 32'h0000_0077);
        check("l1_load_err", 32'(bus1.resp_err), 32'd0);
        @(posedge clk);
        #1;
        check("l1_idle", 32'(bus1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
